// File: rtl/ext_uart_rx.sv
// UART 8N1 receiver that packs bytes MSB-first into an N-bit word for the pico core ext port.
// Optional even parity bit is enabled by defining EXT_UART_RX_PARITY_EN.
module ext_uart_rx #(
  parameter int unsigned N            = 16,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         rx_i,
  output logic [N-1:0] ext_data_o,
  output logic         ext_int_o,
  output logic         frame_err_o
);

  localparam int unsigned BYTES = N / 8;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BC_W  = $clog2(BYTES + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(BYTES - 1);

`ifdef EXT_UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t           state_q;
  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] clkCnt_q;
  logic [2:0]       bitIdx_q;
  logic [7:0]       rxByte_q;
  logic [N-1:0]     word_q;
  logic [BC_W-1:0]  byteCnt_q;
  logic [N-1:0]     extData_q;
  logic             extInt_q;
  logic             frameErr_q;
`ifdef EXT_UART_RX_PARITY_EN
  logic             parityBad_q;
`endif

  logic         rxs;
  logic [N-1:0] wordNext_d;

  assign rxs        = sync2_q;
  assign wordNext_d = (word_q << 8) | N'(rxByte_q);

  assign ext_data_o  = extData_q;
  assign ext_int_o   = extInt_q;
  assign frame_err_o = frameErr_q;

  // Every sample after the start bit lands exactly one bit period after the previous one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      clkCnt_q    <= '0;
      bitIdx_q    <= '0;
      rxByte_q    <= '0;
      word_q      <= '0;
      byteCnt_q   <= '0;
      extData_q   <= '0;
      extInt_q    <= 1'b0;
      frameErr_q  <= 1'b0;
`ifdef EXT_UART_RX_PARITY_EN
      parityBad_q <= 1'b0;
`endif
    end else begin
      sync1_q  <= rx_i;
      sync2_q  <= sync1_q;
      extInt_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!rxs) begin
            clkCnt_q <= '0;
            state_q  <= START;
          end
        end

        START: begin
          if (clkCnt_q == HALF_LAST) begin
            clkCnt_q <= '0;
            if (!rxs) begin
              bitIdx_q    <= '0;
              state_q     <= DATA;
`ifdef EXT_UART_RX_PARITY_EN
              parityBad_q <= 1'b0;
`endif
            end else begin
              state_q <= IDLE;
            end
          end else begin
            clkCnt_q <= clkCnt_q + 1'b1;
          end
        end

        DATA: begin
          if (clkCnt_q == FULL_LAST) begin
            clkCnt_q <= '0;
            rxByte_q <= {rxs, rxByte_q[7:1]};
            bitIdx_q <= bitIdx_q + 1'b1;
            if (bitIdx_q == 3'd7) begin
`ifdef EXT_UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            clkCnt_q <= clkCnt_q + 1'b1;
          end
        end

`ifdef EXT_UART_RX_PARITY_EN
        // A parity failure still walks through STOP so a break is routed to WAIT_IDLE.
        PARITY: begin
          if (clkCnt_q == FULL_LAST) begin
            clkCnt_q <= '0;
            if (rxs != ^rxByte_q) begin
              parityBad_q <= 1'b1;
              frameErr_q  <= 1'b1;
              byteCnt_q   <= '0;
            end
            state_q <= STOP;
          end else begin
            clkCnt_q <= clkCnt_q + 1'b1;
          end
        end
`endif

        STOP: begin
          if (clkCnt_q == FULL_LAST) begin
            clkCnt_q <= '0;
            if (rxs) begin
              state_q <= IDLE;
`ifdef EXT_UART_RX_PARITY_EN
              if (!parityBad_q) begin
`else
              begin
`endif
                word_q <= wordNext_d;
                if (byteCnt_q == LAST_BYTE) begin
                  extData_q <= wordNext_d;
                  extInt_q  <= 1'b1;
                  byteCnt_q <= '0;
                end else begin
                  byteCnt_q <= byteCnt_q + 1'b1;
                end
              end
            end else begin
              frameErr_q <= 1'b1;
              byteCnt_q  <= '0;
              state_q    <= WAIT_IDLE;
            end
          end else begin
            clkCnt_q <= clkCnt_q + 1'b1;
          end
        end

        WAIT_IDLE: begin
          if (rxs) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_uart_rx.sv
// Self-checking bench for ext_uart_rx: directed scenarios plus random frames checked
// against a frame-level reference model (word packing, error stickiness, byte count reset).
module tb_ext_uart_rx;

  localparam int N = 16;
  localparam int C = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rx  = 1'b1;
  logic [N-1:0] extData;
  logic         extInt;
  logic         frameErr;

  ext_uart_rx #(.N(N), .CLKS_PER_BIT(C)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .ext_data_o  (extData),
    .ext_int_o   (extInt),
    .frame_err_o (frameErr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] gotWords[$];
  logic [N-1:0] expWords[$];
  logic [N-1:0] mWord;
  logic [N-1:0] mData;
  int           mCnt;
  logic         mErr;

  // Every cycle the interrupt is seen high counts as one pulse, so a stretched pulse shows up.
  always @(negedge clk) begin
    if (!rst && extInt) gotWords.push_back(extData);
  end

  task automatic clearModel();
    gotWords.delete();
    expWords.delete();
    mWord = '0;
    mData = '0;
    mCnt  = 0;
    mErr  = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic driveBit(input logic v);
    rx = v;
    repeat (C) @(posedge clk);
    #1;
  endtask

  // Reference model: one call per complete frame on the line.
  task automatic modelFrame(input logic [7:0] d, input logic badPar, input logic stopBit);
    logic ok;
    ok = stopBit;
`ifdef EXT_UART_RX_PARITY_EN
    if (badPar) begin
      mErr = 1'b1;
      mCnt = 0;
      ok   = 1'b0;
    end
`else
    if (badPar) ok = ok;
`endif
    if (!stopBit) begin
      mErr = 1'b1;
      mCnt = 0;
    end
    if (ok) begin
      mWord = {mWord[N-9:0], d};
      mCnt++;
      if (mCnt == N / 8) begin
        expWords.push_back(mWord);
        mData = mWord;
        mCnt  = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic badPar,
                               input logic stopBit, input int gap);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
`ifdef EXT_UART_RX_PARITY_EN
    driveBit((^d) ^ badPar);
`endif
    driveBit(stopBit);
    if (gap > 0) idle(gap);
    modelFrame(d, badPar, stopBit);
  endtask

  task automatic test_reset();
    doReset();
    total++;
    if (extData !== '0) begin
      bad++; $display("[TB] FAIL reset_data: got %h expected %h", extData, 16'h0);
    end
    total++;
    if (extInt !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_int: got %b expected 0", extInt);
    end
    total++;
    if (frameErr !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_err: got %b expected 0", frameErr);
    end
  endtask

  task automatic test_two_byte();
    doReset();
    applyStimulus(8'hA5, 1'b0, 1'b1, 4);
    applyStimulus(8'h3C, 1'b0, 1'b1, 2 * C);
    total++;
    if (gotWords.size() !== 1) begin
      bad++; $display("[TB] FAIL two_byte_pulses: got %0d expected 1", gotWords.size());
    end
    total++;
    if (extData !== 16'hA53C) begin
      bad++; $display("[TB] FAIL two_byte_data: got %h expected a53c", extData);
    end
    total++;
    if (frameErr !== 1'b0) begin
      bad++; $display("[TB] FAIL two_byte_err: got %b expected 0", frameErr);
    end
  endtask

  task automatic test_glitch();
    doReset();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(3 * C);
    total++;
    if (gotWords.size() !== 0 || extData !== '0 || frameErr !== 1'b0) begin
      bad++; $display("[TB] FAIL glitch_quiet: got pulses=%0d data=%h err=%b expected 0/0000/0",
                      gotWords.size(), extData, frameErr);
    end
    applyStimulus(8'h5A, 1'b0, 1'b1, 0);
    applyStimulus(8'hC3, 1'b0, 1'b1, 2 * C);
    total++;
    if (gotWords.size() !== 1 || extData !== 16'h5AC3) begin
      bad++; $display("[TB] FAIL glitch_after: got pulses=%0d data=%h expected 1/5ac3",
                      gotWords.size(), extData);
    end
  endtask

  task automatic test_framing();
    doReset();
    applyStimulus(8'h55, 1'b0, 1'b1, 3);
    applyStimulus(8'h11, 1'b0, 1'b0, 0);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idle(C);
    total++;
    if (frameErr !== 1'b1) begin
      bad++; $display("[TB] FAIL framing_err: got %b expected 1", frameErr);
    end
    total++;
    if (gotWords.size() !== 0) begin
      bad++; $display("[TB] FAIL framing_nopulse: got %0d expected 0", gotWords.size());
    end
    applyStimulus(8'h12, 1'b0, 1'b1, 0);
    applyStimulus(8'h34, 1'b0, 1'b1, 2 * C);
    total++;
    if (gotWords.size() !== 1 || extData !== 16'h1234) begin
      bad++; $display("[TB] FAIL framing_recover: got pulses=%0d data=%h expected 1/1234",
                      gotWords.size(), extData);
    end
    total++;
    if (frameErr !== 1'b1) begin
      bad++; $display("[TB] FAIL framing_sticky: got %b expected 1", frameErr);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] second;
    second = 8'hCD;
    doReset();
    applyStimulus(8'h99, 1'b0, 1'b0, C);
    applyStimulus(8'h11, 1'b0, 1'b1, 0);
    applyStimulus(8'h22, 1'b0, 1'b1, C);
    applyStimulus(8'hAB, 1'b0, 1'b1, 0);
    driveBit(1'b0);
    for (int i = 0; i < 3; i++) driveBit(second[i]);
    rx = second[3];
    repeat (C / 2) @(posedge clk);
    #1;
    total++;
    if (extData !== 16'h1122 || frameErr !== 1'b1) begin
      bad++; $display("[TB] FAIL midreset_pre: got data=%h err=%b expected 1122/1", extData, frameErr);
    end
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (extData !== '0 || extInt !== 1'b0 || frameErr !== 1'b0) begin
      bad++; $display("[TB] FAIL midreset_outputs: got data=%h int=%b err=%b expected 0/0/0",
                      extData, extInt, frameErr);
    end
    rst = 1'b0;
    clearModel();
    idle(C);
    applyStimulus(8'hBE, 1'b0, 1'b1, 0);
    applyStimulus(8'hEF, 1'b0, 1'b1, 2 * C);
    total++;
    if (gotWords.size() !== 1 || extData !== 16'hBEEF) begin
      bad++; $display("[TB] FAIL midreset_after: got pulses=%0d data=%h expected 1/beef",
                      gotWords.size(), extData);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    applyStimulus(8'h01, 1'b0, 1'b1, 0);
    applyStimulus(8'h02, 1'b0, 1'b1, 0);
    applyStimulus(8'h03, 1'b0, 1'b1, 0);
    applyStimulus(8'h04, 1'b0, 1'b1, 2 * C);
    total++;
    if (gotWords.size() !== 2) begin
      bad++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", gotWords.size());
    end
    total++;
    if (((gotWords.size() > 0) ? gotWords[0] : 'x) !== 16'h0102) begin
      bad++; $display("[TB] FAIL b2b_word0: got %h expected 0102",
                      (gotWords.size() > 0) ? gotWords[0] : 'x);
    end
    total++;
    if (((gotWords.size() > 1) ? gotWords[1] : 'x) !== 16'h0304) begin
      bad++; $display("[TB] FAIL b2b_word1: got %h expected 0304",
                      (gotWords.size() > 1) ? gotWords[1] : 'x);
    end
  endtask

`ifdef EXT_UART_RX_PARITY_EN
  task automatic test_parity();
    doReset();
    applyStimulus(8'h07, 1'b1, 1'b1, C);
    total++;
    if (frameErr !== 1'b1 || gotWords.size() !== 0) begin
      bad++; $display("[TB] FAIL parity_err: got err=%b pulses=%0d expected 1/0",
                      frameErr, gotWords.size());
    end
    applyStimulus(8'h07, 1'b0, 1'b1, 0);
    applyStimulus(8'h08, 1'b0, 1'b1, 2 * C);
    total++;
    if (gotWords.size() !== 1 || extData !== 16'h0708) begin
      bad++; $display("[TB] FAIL parity_recover: got pulses=%0d data=%h expected 1/0708",
                      gotWords.size(), extData);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] d;
    logic       stopBit;
    logic       badPar;
    int         gap;
    doReset();
    for (int f = 0; f < 30; f++) begin
      d       = 8'($urandom);
      stopBit = ($urandom_range(0, 7) != 0);
      badPar  = ($urandom_range(0, 7) == 0);
      gap     = stopBit ? $urandom_range(0, 3) : C + $urandom_range(0, 8);
      applyStimulus(d, badPar, stopBit, gap);
    end
    idle(2 * C);
    total++;
    if (gotWords.size() !== expWords.size()) begin
      bad++; $display("[TB] FAIL random_count: got %0d expected %0d", gotWords.size(), expWords.size());
    end
    for (int i = 0; i < expWords.size(); i++) begin
      total++;
      if (((i < gotWords.size()) ? gotWords[i] : 'x) !== expWords[i]) begin
        bad++; $display("[TB] FAIL random_word%0d: got %h expected %h", i,
                        (i < gotWords.size()) ? gotWords[i] : 'x, expWords[i]);
      end
    end
    total++;
    if (extData !== mData) begin
      bad++; $display("[TB] FAIL random_data: got %h expected %h", extData, mData);
    end
    total++;
    if (frameErr !== mErr) begin
      bad++; $display("[TB] FAIL random_err: got %b expected %b", frameErr, mErr);
    end
  endtask

  initial begin
    clearModel();
    test_reset();
    test_two_byte();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_back_to_back();
`ifdef EXT_UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
